imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, instruction address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, instruction word width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 2, number of core fetchers sharing the one memory channel.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous invalidate of the last-fetch buffer (pulsed at kernel start).
REQ-007 SHALL have port consumer_read_request  input  NUM_CONSUMERS  per-fetcher request level.
REQ-008 SHALL have port consumer_read_address  input  ADDR_BITS x NUM_CONSUMERS  per-fetcher address, stable while request high.
REQ-009 SHALL have port consumer_read_ready  output  NUM_CONSUMERS  per-fetcher response valid.
REQ-010 SHALL have port consumer_read_data  output  DATA_BITS x NUM_CONSUMERS  per-fetcher instruction word.
REQ-011 SHALL have port mem_read_request  output  1  instruction memory request level.
REQ-012 SHALL have port mem_read_address  output  ADDR_BITS  instruction memory address.
REQ-013 SHALL have port mem_read_ready  input  1  memory data valid.
REQ-014 SHALL have port mem_read_data  input  DATA_BITS  memory instruction word.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, RESPOND; all outputs registered.
REQ-016 SHALL, in IDLE with any request high, grant the first requester at or after rr_ptr (modulo NUM_CONSUMERS), latch grant index and address.
REQ-017 SHALL, on grant, go to RESPOND if buffer_valid and latched address equals buffer_addr (hit, no memory access); else go to FETCH.
REQ-018 SHALL, in FETCH, hold mem_read_request=1 and mem_read_address=granted address until the cycle mem_read_ready=1 is sampled.
REQ-019 SHALL, on mem_read_ready, capture mem_read_data into buffer_data, set buffer_addr, set buffer_valid, drop mem_read_request next cycle, enter RESPOND.
REQ-020 SHALL, in RESPOND, drive consumer_read_ready[grant]=1 and consumer_read_data[grant]=buffer_data; non-granted ready bits stay 0.
REQ-021 SHALL hold RESPOND until consumer_read_request[grant]=0 is sampled, then clear ready, set rr_ptr=grant+1 (wrapping NUM_CONSUMERS-1 to 0), return to IDLE.
REQ-022 SHALL give hit latency of 2 cycles request-to-ready and miss latency of 2 cycles plus memory latency.
REQ-023 SHALL keep consumer_read_data[k] holding its last value when not granted.
REQ-024 SHALL ignore consumer requests arriving while busy; they are served in later IDLE arbitration (no loss, level-based).
REQ-025 SHALL, on flush, clear buffer_valid; flush coincident with a FETCH fill leaves buffer_valid=0 but the pending consumer still receives the fetched word.
REQ-026 SHALL guarantee each requester is granted within NUM_CONSUMERS transactions (starvation-free).

Reset
REQ-027 SHALL, while reset=0, force state=IDLE, rr_ptr=0, buffer_valid=0, buffer_addr=0, buffer_data=0, mem_read_request=0, mem_read_address=0, all consumer_read_ready=0, all consumer_read_data=0.
REQ-028 SHALL abandon any in-flight fetch on reset assertion; memory response arriving after release is ignored in IDLE.

Verification
REQ-029 SHALL verify miss: consumer0 requests 0x05, memory returns 0xABCD after 3 cycles -> one mem request at 0x05, consumer_read_ready[0]=1 with data 0xABCD.
REQ-030 SHALL verify hit: repeat 0x05 from consumer1 -> ready[1] in 2 cycles with 0xABCD, mem_read_request stays 0.
REQ-031 SHALL verify round-robin: both consumers request continuously with distinct addresses -> grants alternate 0,1,0,1.
REQ-032 SHALL verify flush: flush pulse then consumer0 requests 0x05 -> new memory fetch at 0x05.
REQ-033 SHALL verify reset mid-FETCH: reset=0 while mem_read_request=1 -> all outputs 0 immediately, late mem_read_ready causes no consumer ready.
REQ-034 SHALL verify handshake hold: consumer keeps request high 5 cycles after ready -> ready stays 1 for those cycles, no new grant until request drops.

Source files
------------

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin instruction memory arbiter with one-entry last-fetch buffer

module imem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      flush,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_request,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
    output logic                                      mem_read_request,
    output logic [ADDR_BITS-1:0]                      mem_read_address,
    input  logic                                      mem_read_ready,
    input  logic [DATA_BITS-1:0]                      mem_read_data
);

    localparam int GW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                                  state_q, state_d;
    logic [GW-1:0]                           grant_q, grant_d;
    logic [GW-1:0]                           rr_q, rr_d;
    logic [ADDR_BITS-1:0]                    addr_q, addr_d;
    logic                                    buf_valid_q, buf_valid_d;
    logic [ADDR_BITS-1:0]                    buf_addr_q, buf_addr_d;
    logic [DATA_BITS-1:0]                    buf_data_q, buf_data_d;
    logic                                    mem_req_q, mem_req_d;
    logic [ADDR_BITS-1:0]                    mem_addr_q, mem_addr_d;
    logic [NUM_CONSUMERS-1:0]                ready_q, ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q, data_d;

    logic                                    found;
    logic [GW-1:0]                           pick;
    logic [GW-1:0]                           cand;
    logic [ADDR_BITS-1:0]                    pick_addr;
    logic [GW-1:0]                           rr_after_grant;

    // Round-robin search: first requester at or after rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            cand = GW'((int'(rr_q) + i) % NUM_CONSUMERS);
            if (!found && consumer_read_request[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign pick_addr      = consumer_read_address[pick];
    assign rr_after_grant = (grant_q == GW'(NUM_CONSUMERS - 1)) ? '0 : grant_q + GW'(1);

    // Next-state and registered-output computation for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        addr_d      = addr_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        ready_d     = ready_q;
        data_d      = data_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    addr_d  = pick_addr;
                    // A flush in the grant cycle must not let stale data hit.
                    if (buf_valid_q && !flush && (pick_addr == buf_addr_q)) begin
                        state_d = RESPOND;
                    end else begin
                        state_d    = FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pick_addr;
                    end
                end
            end
            FETCH: begin
                if (mem_read_ready) begin
                    buf_data_d  = mem_read_data;
                    buf_addr_d  = addr_q;
                    buf_valid_d = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                if (consumer_read_request[grant_q]) begin
                    ready_d[grant_q] = 1'b1;
                    data_d[grant_q]  = buf_data_q;
                end else begin
                    ready_d[grant_q] = 1'b0;
                    rr_d             = rr_after_grant;
                    state_d          = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over a coincident fill; the word is still delivered.
        if (flush) begin
            buf_valid_d = 1'b0;
        end
    end

    // State register; reset abandons any in-flight fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            addr_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            ready_q     <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            addr_q      <= addr_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
        end
    end

    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = data_q;
    assign mem_read_request    = mem_req_q;
    assign mem_read_address    = mem_addr_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter

module tb_imem_arbiter;

    localparam int MEM_LAT = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush;
    logic             flush_cmd = 1'b0;
    logic             flush_fill = 1'b0;
    logic [1:0]       c_req = 2'b00;
    logic [1:0][7:0]  c_addr = '0;
    logic [1:0]       c_ready;
    logic [1:0][15:0] c_data;
    logic             mem_req;
    logic [7:0]       mem_addr;
    logic             mem_ready;
    logic             model_ready = 1'b0;
    logic             manual_ready = 1'b0;
    logic [15:0]      mem_data = '0;

    logic             mem_auto = 1'b1;
    logic             fill_flush = 1'b0;
    int               mem_cnt = 0;
    logic [7:0]       mem_last_addr = '0;
    logic             mem_req_prev = 1'b0;
    int               lat_cnt = 0;

    int               errors = 0;
    int               checks = 0;

    assign flush     = flush_cmd | flush_fill;
    assign mem_ready = model_ready | manual_ready;

    imem_arbiter #(
        .ADDR_BITS    (8),
        .DATA_BITS    (16),
        .NUM_CONSUMERS(2)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .flush                (flush),
        .consumer_read_request(c_req),
        .consumer_read_address(c_addr),
        .consumer_read_ready  (c_ready),
        .consumer_read_data   (c_data),
        .mem_read_request     (mem_req),
        .mem_read_address     (mem_addr),
        .mem_read_ready       (mem_ready),
        .mem_read_data        (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        if (a == 8'h05) return 16'hABCD;
        return {a, ~a};
    endfunction

    // Memory model: answers MEM_LAT negedges after the request rises.
    always @(negedge clk) begin
        if (mem_req && !mem_req_prev) begin
            mem_cnt++;
            mem_last_addr = mem_addr;
        end
        mem_req_prev = mem_req;
        if (model_ready) begin
            model_ready = 1'b0;
            flush_fill  = 1'b0;
            lat_cnt     = 0;
        end else if (mem_req && mem_auto) begin
            lat_cnt++;
            if (lat_cnt == MEM_LAT) begin
                model_ready = 1'b1;
                mem_data    = mem_word(mem_addr);
                flush_fill  = fill_flush;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int k, input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!c_ready[k] && cyc < 60);
        if (!c_ready[k]) check({tag, "_timeout"}, 32'(c_ready[k]), 32'd1);
    endtask

    // Single transaction from consumer k; checks latency, data, release.
    task automatic serve(input int k, input logic [7:0] a, input int exp_lat, input string tag);
        int cyc;
        c_addr[k] = a;
        c_req[k]  = 1'b1;
        wait_ready(k, tag, cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_data"}, 32'(c_data[k]), 32'(mem_word(a)));
        c_req[k] = 1'b0;
        @(negedge clk);
        check({tag, "_rdy_clr"}, 32'(c_ready), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int cnt0;
        int cyc;
        int which;
        int grants [4];

        // Reset state
        #2;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_ready", 32'(c_ready), 32'd0);
        check("rst_data", c_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Miss then hit on 0x05
        cnt0 = mem_cnt;
        serve(0, 8'h05, 2 + MEM_LAT, "miss05");
        check("miss05_memcnt", 32'(mem_cnt - cnt0), 32'd1);
        check("miss05_memaddr", 32'(mem_last_addr), 32'h05);
        cnt0 = mem_cnt;
        serve(1, 8'h05, 2, "hit05");
        check("hit05_memcnt", 32'(mem_cnt - cnt0), 32'd0);

        // Round-robin with both consumers requesting continuously
        c_addr[0] = 8'h10;
        c_addr[1] = 8'h20;
        c_req     = 2'b11;
        for (int n = 0; n < 4; n++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (c_ready == 2'b00 && cyc < 60);
            if (c_ready == 2'b00) check("rr_timeout", 32'(c_ready), 32'd1);
            which     = c_ready[1] ? 1 : 0;
            grants[n] = which;
            check("rr_data", 32'(c_data[which]), 32'(mem_word(c_addr[which])));
            check("rr_onehot", 32'(c_ready), (which == 1) ? 32'd2 : 32'd1);
            c_req[which] = 1'b0;
            @(negedge clk);
            if (n < 3) c_req[which] = 1'b1;
            else c_req = 2'b00;
        end
        check("rr_g0", 32'(grants[0]), 32'd0);
        check("rr_g1", 32'(grants[1]), 32'd1);
        check("rr_g2", 32'(grants[2]), 32'd0);
        check("rr_g3", 32'(grants[3]), 32'd1);
        repeat (2) @(negedge clk);

        // Flush forces a refetch of a buffered address
        serve(0, 8'h05, 2 + MEM_LAT, "refill05");
        serve(1, 8'h05, 2, "rehit05");
        flush_cmd = 1'b1;
        @(negedge clk);
        flush_cmd = 1'b0;
        cnt0 = mem_cnt;
        serve(0, 8'h05, 2 + MEM_LAT, "flush05");
        check("flush05_memcnt", 32'(mem_cnt - cnt0), 32'd1);
        check("flush05_memaddr", 32'(mem_last_addr), 32'h05);

        // Flush coincident with fill: word delivered, buffer left invalid
        fill_flush = 1'b1;
        serve(0, 8'h30, 2 + MEM_LAT, "ffill30");
        fill_flush = 1'b0;
        cnt0 = mem_cnt;
        serve(1, 8'h30, 2 + MEM_LAT, "after_ffill30");
        check("after_ffill_memcnt", 32'(mem_cnt - cnt0), 32'd1);

        // Reset during FETCH; late memory response must be ignored
        mem_auto  = 1'b0;
        c_addr[0] = 8'h40;
        c_req[0]  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_req && cyc < 20);
        check("rstf_req_seen", 32'(mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstf_mem_req", 32'(mem_req), 32'd0);
        check("rstf_mem_addr", 32'(mem_addr), 32'd0);
        check("rstf_ready", 32'(c_ready), 32'd0);
        check("rstf_data", c_data, 32'd0);
        c_req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        manual_ready = 1'b1;
        mem_data     = 16'h1234;
        @(negedge clk);
        manual_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("rstf_late_ready", 32'(c_ready), 32'd0);
            check("rstf_late_memreq", 32'(mem_req), 32'd0);
        end
        mem_auto = 1'b1;

        // Handshake hold: ready stays while request stays, no new grant
        c_addr[0] = 8'h05;
        c_addr[1] = 8'h06;
        c_req     = 2'b11;
        wait_ready(0, "hold0", cyc);
        check("hold0_lat", 32'(cyc), 32'(2 + MEM_LAT));
        check("hold0_data", 32'(c_data[0]), 32'hABCD);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("hold_ready", 32'(c_ready), 32'd1);
            check("hold_memreq", 32'(mem_req), 32'd0);
        end
        c_req[0] = 1'b0;
        wait_ready(1, "hold1", cyc);
        check("hold1_data", 32'(c_data[1]), 32'h06F9);
        check("hold_keep0", 32'(c_data[0]), 32'hABCD);
        check("hold1_onehot", 32'(c_ready), 32'd2);
        c_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("end_ready", 32'(c_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
